// File: rtl/guess_entry.sv
// ============================================================================
//  Module      : guess_entry
//  Description : Keypad-to-guess stage. Debounces scanner key codes, assembles
//                four unique decimal digits with backspace/enter, presents the
//                guess over valid/ready and counts accepted attempts.
//                Optional macro GUESS_AUTO_SUBMIT_EN: the 4th digit submits
//                the guess directly and enter is always rejected.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module guess_entry #(
    parameter int          DEBOUNCE  = 4,
    parameter int          DEB_W     = 3,
    parameter logic [3:0]  KEY_NONE  = 4'hF,
    parameter logic [3:0]  KEY_BKSP  = 4'hA,
    parameter logic [3:0]  KEY_ENTER = 4'hB,
    parameter int          ATT_MAX   = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] key_code,
    output logic [3:0] q1,
    output logic [3:0] q2,
    output logic [3:0] q3,
    output logic [3:0] q4,
    output logic [2:0] count,
    output logic       guess_valid,
    input  logic       guess_ready,
    output logic       err,
    output logic [6:0] attempts
);

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    localparam logic [1:0] c_wait_press = 2'd0;
    localparam logic [1:0] c_confirm    = 2'd1;
    localparam logic [1:0] c_wait_rel   = 2'd2;

    localparam logic [DEB_W-1:0] c_deb_last = DEB_W'(DEBOUNCE - 1);
    localparam logic [DEB_W-1:0] c_deb_one  = DEB_W'(1);
    localparam logic             c_deb_single = (DEBOUNCE <= 1);

    logic [1:0]       r_deb_state;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [3:0]       r_key;
    logic             r_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_state <= c_wait_press;
            r_deb_cnt   <= '0;
            r_key       <= KEY_NONE;
            r_evt       <= 1'b0;
        end else begin
            r_evt <= 1'b0;
            if (tick) begin
                case (r_deb_state)
                    c_wait_press: begin
                        if (key_code != KEY_NONE) begin
                            r_key <= key_code;
                            if (c_deb_single) begin
                                r_evt       <= 1'b1;
                                r_deb_cnt   <= '0;
                                r_deb_state <= c_wait_rel;
                            end else begin
                                r_deb_cnt   <= c_deb_one;
                                r_deb_state <= c_confirm;
                            end
                        end
                    end
                    c_confirm: begin
                        if (key_code == r_key) begin
                            if (r_deb_cnt == c_deb_last) begin
                                r_evt       <= 1'b1;
                                r_deb_cnt   <= '0;
                                r_deb_state <= c_wait_rel;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + c_deb_one;
                            end
                        end else begin
                            r_deb_cnt   <= '0;
                            r_deb_state <= c_wait_press;
                        end
                    end
                    c_wait_rel: begin
                        // Release needs an unbroken run of NONE samples.
                        if (key_code == KEY_NONE) begin
                            if (r_deb_cnt == c_deb_last) begin
                                r_deb_cnt   <= '0;
                                r_deb_state <= c_wait_press;
                            end else begin
                                r_deb_cnt <= r_deb_cnt + c_deb_one;
                            end
                        end else begin
                            r_deb_cnt <= '0;
                        end
                    end
                    default: begin
                        r_deb_cnt   <= '0;
                        r_deb_state <= c_wait_press;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM
    // ------------------------------------------------------------------
    localparam logic [1:0] c_entry   = 2'd0;
    localparam logic [1:0] c_full    = 2'd1;
    localparam logic [1:0] c_present = 2'd2;

    localparam logic [6:0] c_att_max = 7'(ATT_MAX);

`ifdef GUESS_AUTO_SUBMIT_EN
    localparam logic [1:0] c_fourth_state = c_present;
    localparam logic       c_auto         = 1'b1;
`else
    localparam logic [1:0] c_fourth_state = c_full;
    localparam logic       c_auto         = 1'b0;
`endif

    logic [1:0] r_state;
    logic [3:0] r_slot [4];
    logic [2:0] r_count;
    logic       r_err;
    logic [6:0] r_attempts;

    logic w_is_digit;
    logic w_is_bksp;
    logic w_is_enter;
    logic w_dup;
    logic w_handshake;

    always_comb begin
        w_is_digit  = (r_key <= 4'd9);
        w_is_bksp   = (r_key == KEY_BKSP);
        w_is_enter  = (r_key == KEY_ENTER);
        // Empty slots hold F, which never matches a digit.
        w_dup       = (r_slot[0] == r_key) || (r_slot[1] == r_key) ||
                      (r_slot[2] == r_key) || (r_slot[3] == r_key);
        w_handshake = (r_state == c_present) && guess_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_entry;
            r_count    <= 3'd0;
            r_err      <= 1'b0;
            r_attempts <= 7'd0;
            for (int i = 0; i < 4; i++) r_slot[i] <= KEY_NONE;
        end else begin
            r_err <= 1'b0;
            if (w_handshake) begin
                // Any event landing on the handshake cycle is dropped.
                for (int i = 0; i < 4; i++) r_slot[i] <= KEY_NONE;
                r_count <= 3'd0;
                r_state <= c_entry;
                if (r_attempts != c_att_max) r_attempts <= r_attempts + 7'd1;
            end else if (r_evt) begin
                case (r_state)
                    c_entry: begin
                        if (w_is_digit) begin
                            if (w_dup) begin
                                r_err <= 1'b1;
                            end else begin
                                r_slot[r_count[1:0]] <= r_key;
                                r_count              <= r_count + 3'd1;
                                if (r_count == 3'd3) r_state <= c_fourth_state;
                            end
                        end else if (w_is_bksp) begin
                            if (r_count != 3'd0) begin
                                r_slot[r_count[1:0] - 2'd1] <= KEY_NONE;
                                r_count                     <= r_count - 3'd1;
                            end
                        end else if (w_is_enter) begin
                            r_err <= 1'b1;
                        end
                    end
                    c_full: begin
                        if (w_is_digit) begin
                            r_err <= 1'b1;
                        end else if (w_is_bksp) begin
                            r_slot[3] <= KEY_NONE;
                            r_count   <= r_count - 3'd1;
                            r_state   <= c_entry;
                        end else if (w_is_enter) begin
                            if (c_auto) r_err   <= 1'b1;
                            else        r_state <= c_present;
                        end
                    end
                    c_present: begin
                        // Only auto-submit rejects enter here; all else drops.
                        if (w_is_enter && c_auto) r_err <= 1'b1;
                    end
                    default: begin
                        r_state <= c_entry;
                    end
                endcase
            end
        end
    end

    assign q1          = r_slot[0];
    assign q2          = r_slot[1];
    assign q3          = r_slot[2];
    assign q4          = r_slot[3];
    assign count       = r_count;
    assign guess_valid = (r_state == c_present);
    assign err         = r_err;
    assign attempts    = r_attempts;

endmodule

`default_nettype wire

// File: tb/tb_guess_entry.sv
// ============================================================================
//  Module      : tb_guess_entry
//  Description : Self-checking bench for guess_entry (vector table + scoreboard).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_guess_entry;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] key_code = 4'hF;
    logic [3:0] q1, q2, q3, q4;
    logic [2:0] count;
    logic       guess_valid;
    logic       guess_ready = 1'b0;
    logic       err;
    logic [6:0] attempts;

    guess_entry dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .key_code   (key_code),
        .q1         (q1),
        .q2         (q2),
        .q3         (q3),
        .q4         (q4),
        .count      (count),
        .guess_valid(guess_valid),
        .guess_ready(guess_ready),
        .err        (err),
        .attempts   (attempts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  key;
        logic        err;
        logic [15:0] q;
        logic [2:0]  cnt;
        logic        valid;
    } vec_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    int   err_seen = 0;
    logic err_prev = 1'b0;
    vec_t sb_q [$];

    always @(negedge clk) begin
        if (err) err_seen++;
        if (err && err_prev) begin
            n_fail++;
            $display("FAIL err_width: err high 2 cycles in a row, got 1 required 0");
        end
        err_prev = err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick_once(input logic [3:0] c);
        key_code = c;
        tick     = 1'b1;
        @(posedge clk); #1;
        tick     = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic press(input logic [3:0] c, input int n);
        err_seen = 0;
        repeat (n) tick_once(c);
        repeat (DEB + 2) tick_once(4'hF);
    endtask

    function automatic logic [15:0] qv();
        return {q1, q2, q3, q4};
    endfunction

`ifdef GUESS_AUTO_SUBMIT_EN
    localparam int          N_VEC = 12;
    localparam logic [15:0] HS_Q  = 16'h9876;
`else
    localparam int          N_VEC = 13;
    localparam logic [15:0] HS_Q  = 16'h1235;
`endif

    vec_t vecs [N_VEC];
    vec_t exp_v;

    initial begin
`ifdef GUESS_AUTO_SUBMIT_EN
        vecs[0]  = '{4'h9, 1'b0, 16'h9FFF, 3'd1, 1'b0};
        vecs[1]  = '{4'h8, 1'b0, 16'h98FF, 3'd2, 1'b0};
        vecs[2]  = '{4'h8, 1'b1, 16'h98FF, 3'd2, 1'b0};
        vecs[3]  = '{4'hB, 1'b1, 16'h98FF, 3'd2, 1'b0};
        vecs[4]  = '{4'h7, 1'b0, 16'h987F, 3'd3, 1'b0};
        vecs[5]  = '{4'hB, 1'b1, 16'h987F, 3'd3, 1'b0};
        vecs[6]  = '{4'hA, 1'b0, 16'h98FF, 3'd2, 1'b0};
        vecs[7]  = '{4'h7, 1'b0, 16'h987F, 3'd3, 1'b0};
        vecs[8]  = '{4'hC, 1'b0, 16'h987F, 3'd3, 1'b0};
        vecs[9]  = '{4'h6, 1'b0, 16'h9876, 3'd4, 1'b1};
        vecs[10] = '{4'h5, 1'b0, 16'h9876, 3'd4, 1'b1};
        vecs[11] = '{4'hB, 1'b1, 16'h9876, 3'd4, 1'b1};
`else
        vecs[0]  = '{4'h1, 1'b0, 16'h1FFF, 3'd1, 1'b0};
        vecs[1]  = '{4'h2, 1'b0, 16'h12FF, 3'd2, 1'b0};
        vecs[2]  = '{4'h2, 1'b1, 16'h12FF, 3'd2, 1'b0};
        vecs[3]  = '{4'hB, 1'b1, 16'h12FF, 3'd2, 1'b0};
        vecs[4]  = '{4'h3, 1'b0, 16'h123F, 3'd3, 1'b0};
        vecs[5]  = '{4'hB, 1'b1, 16'h123F, 3'd3, 1'b0};
        vecs[6]  = '{4'h4, 1'b0, 16'h1234, 3'd4, 1'b0};
        vecs[7]  = '{4'h5, 1'b1, 16'h1234, 3'd4, 1'b0};
        vecs[8]  = '{4'hA, 1'b0, 16'h123F, 3'd3, 1'b0};
        vecs[9]  = '{4'h5, 1'b0, 16'h1235, 3'd4, 1'b0};
        vecs[10] = '{4'hC, 1'b0, 16'h1235, 3'd4, 1'b0};
        vecs[11] = '{4'hB, 1'b0, 16'h1235, 3'd4, 1'b1};
        vecs[12] = '{4'h7, 1'b0, 16'h1235, 3'd4, 1'b1};
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_q",        32'(qv()),        32'hFFFF);
        check("rst_count",    32'(count),       32'd0);
        check("rst_valid",    32'(guess_valid), 32'd0);
        check("rst_err",      32'(err),         32'd0);
        check("rst_attempts", 32'(attempts),    32'd0);

        // Table of single key presses
        for (int i = 0; i < N_VEC; i++) begin
            sb_q.push_back(vecs[i]);
            press(vecs[i].key, DEB + 2);
            exp_v = sb_q.pop_front();
            check($sformatf("v%0d_err", i),   32'(err_seen),    32'(exp_v.err));
            check($sformatf("v%0d_q", i),     32'(qv()),        32'(exp_v.q));
            check($sformatf("v%0d_count", i), 32'(count),       32'(exp_v.cnt));
            check($sformatf("v%0d_valid", i), 32'(guess_valid), 32'(exp_v.valid));
        end

        // Consumer stalls: guess held stable
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(guess_valid), 32'd1);
            check("stall_q",     32'(qv()),        32'(HS_Q));
        end
        @(posedge clk); #1;
        guess_ready = 1'b1;
        @(posedge clk); #1;
        guess_ready = 1'b0;
        check("hs_valid",    32'(guess_valid), 32'd0);
        check("hs_q",        32'(qv()),        32'hFFFF);
        check("hs_count",    32'(count),       32'd0);
        check("hs_attempts", 32'(attempts),    32'd1);

        // Backspace on empty guess: silent
        press(4'hA, DEB + 2);
        check("bksp0_err",   32'(err_seen), 32'd0);
        check("bksp0_count", 32'(count),    32'd0);

        // Short press is filtered
        press(4'h1, DEB - 1);
        check("short_count", 32'(count),    32'd0);
        check("short_err",   32'(err_seen), 32'd0);

        // Long hold gives exactly one event
        press(4'h1, 10);
        check("hold_count", 32'(count),    32'd1);
        check("hold_q",     32'(qv()),     32'h1FFF);
        check("hold_err",   32'(err_seen), 32'd0);

        // Ready outside PRESENT is ignored
        guess_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 guess_ready = 1'b0;
        check("idle_ready_count",    32'(count),    32'd1);
        check("idle_ready_attempts", 32'(attempts), 32'd1);

        // Reset while presenting a guess
        press(4'h2, DEB + 2);
        press(4'h3, DEB + 2);
        press(4'h4, DEB + 2);
`ifndef GUESS_AUTO_SUBMIT_EN
        press(4'hB, DEB + 2);
`endif
        check("pre_rst_valid", 32'(guess_valid), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("mid_rst_q",        32'(qv()),        32'hFFFF);
        check("mid_rst_count",    32'(count),       32'd0);
        check("mid_rst_valid",    32'(guess_valid), 32'd0);
        check("mid_rst_attempts", 32'(attempts),    32'd0);
        err_seen = 0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_quiet", 32'(err_seen + 32'(count)), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
